// File: rtl/decode_stage.sv
// RV32I decode stage behind fetch_WB: realigns {pc, instr} across the one-cycle RAM latency,
// decodes fields and immediates, reads the register file and owns its write port.

module decode_stage_chk (
  input logic iClk,
  input logic iRst,
  input logic iOverflow
);
  // The noOp feedback bounds occupancy at two; a push into a full FIFO means that loop is broken.
  skidOverflowA: assert property (@(posedge iClk) disable iff (iRst) !iOverflow);
endmodule

module decode_stage #(
  parameter int cXLEN   = 32,
  parameter int cRegNum = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [cXLEN-1:0] iCurPc,
  input  logic [cXLEN-1:0] iInstr,
  input  logic             iFlush,
  input  logic             iStall,
  input  logic             iRegWrDv,
  input  logic [4:0]       iRegWrAddr,
  input  logic [cXLEN-1:0] iRegWrData,
  output logic             oFetchNoOp,
  output logic             oValid,
  output logic [cXLEN-1:0] oPc,
  output logic [cXLEN-1:0] oInstr,
  output logic [6:0]       oOpcode,
  output logic [2:0]       oFunct3,
  output logic [6:0]       oFunct7,
  output logic [4:0]       oRdAddr,
  output logic [4:0]       oRs1Addr,
  output logic [4:0]       oRs2Addr,
  output logic [cXLEN-1:0] oRs1Data,
  output logic [cXLEN-1:0] oRs2Data,
  output logic [cXLEN-1:0] oImm,
  output logic             oIllegal
);

  logic [cXLEN-1:0]              pcD1_r;
  logic                          noOpD1_r, noOpD2_r, squashCnt_r;
  logic [1:0]                    fifoCnt_r;
  logic [cXLEN-1:0]              fifoPc_r [2];
  logic [cXLEN-1:0]              fifoInstr_r [2];
  logic [cRegNum-1:0][cXLEN-1:0] regs_r;

  logic             inFresh_s, useFifo_s, haveSrc_s, loadOut_s, push_s, pop_s;
  logic             wrEn_s, overflow_s, ill_s;
  logic [cXLEN-1:0] srcPc_s, srcInstr_s, rs1Data_s, rs2Data_s, heldRs1_s, heldRs2_s, imm_s;
  logic [4:0]       rs1_s, rs2_s;

  // Returns {illegal, immediate}; unsupported encodings yield a zero immediate.
  function automatic logic [cXLEN:0] decodeImm(input logic [cXLEN-1:0] ins);
    logic [cXLEN-1:0] imm;
    logic             ill;
    imm = {cXLEN{1'b0}};
    ill = 1'b0;
    if (ins[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (ins[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
          imm = {{(cXLEN-12){ins[31]}}, ins[31:20]};
        7'b0100011: imm = {{(cXLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
        7'b1100011: imm = {{(cXLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        7'b0110111, 7'b0010111: imm = {ins[31:12], 12'd0};
        7'b1101111: imm = {{(cXLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        7'b0110011, 7'b0001111: imm = {cXLEN{1'b0}};
        default: ill = 1'b1;
      endcase
    end
    return {ill, imm};
  endfunction

  assign oFetchNoOp = iStall & ~iFlush;

  // Source selection, FIFO push/pop control and register reads with write-first bypass.
  always_comb begin
    inFresh_s  = ~iFlush & ~squashCnt_r & ~noOpD2_r;
    useFifo_s  = (fifoCnt_r != 2'd0);
    if (useFifo_s) begin
      srcPc_s    = fifoPc_r[0];
      srcInstr_s = fifoInstr_r[0];
    end else begin
      srcPc_s    = pcD1_r;
      srcInstr_s = iInstr;
    end
    haveSrc_s  = useFifo_s | inFresh_s;
    loadOut_s  = ~iFlush & ~iStall & haveSrc_s;
    pop_s      = ~iFlush & ~iStall & useFifo_s;
    push_s     = inFresh_s & (iStall | useFifo_s);
    overflow_s = push_s & ~pop_s & (fifoCnt_r == 2'd2);
    wrEn_s     = iRegWrDv & (iRegWrAddr != 5'd0);
    rs1_s      = srcInstr_s[19:15];
    rs2_s      = srcInstr_s[24:20];
    if (rs1_s == 5'd0) begin
      rs1Data_s = {cXLEN{1'b0}};
    end else if (wrEn_s && (iRegWrAddr == rs1_s)) begin
      rs1Data_s = iRegWrData;
    end else begin
      rs1Data_s = regs_r[rs1_s];
    end
    if (rs2_s == 5'd0) begin
      rs2Data_s = {cXLEN{1'b0}};
    end else if (wrEn_s && (iRegWrAddr == rs2_s)) begin
      rs2Data_s = iRegWrData;
    end else begin
      rs2Data_s = regs_r[rs2_s];
    end
    // wrEn_s already excludes x0, so a held x0 operand never picks up a write.
    heldRs1_s = (wrEn_s && (iRegWrAddr == oRs1Addr)) ? iRegWrData : oRs1Data;
    heldRs2_s = (wrEn_s && (iRegWrAddr == oRs2Addr)) ? iRegWrData : oRs2Data;
    {ill_s, imm_s} = decodeImm(srcInstr_s);
  end

  // RAM-latency alignment, noOp history and post-redirect squash.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pcD1_r      <= {cXLEN{1'b0}};
      noOpD1_r    <= 1'b0;
      noOpD2_r    <= 1'b0;
      squashCnt_r <= 1'b1;
    end else begin
      pcD1_r      <= iCurPc;
      noOpD1_r    <= oFetchNoOp;
      noOpD2_r    <= noOpD1_r;
      squashCnt_r <= iFlush;
    end
  end

  // Register file write port; only reset blocks writes.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      regs_r <= {(cRegNum*cXLEN){1'b0}};
    end else if (wrEn_s) begin
      regs_r[iRegWrAddr] <= iRegWrData;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Two-entry skid FIFO; entry 0 is the head.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      fifoCnt_r      <= 2'd0;
      fifoPc_r[0]    <= {cXLEN{1'b0}};
      fifoPc_r[1]    <= {cXLEN{1'b0}};
      fifoInstr_r[0] <= {cXLEN{1'b0}};
      fifoInstr_r[1] <= {cXLEN{1'b0}};
    end else if (iFlush) begin
      fifoCnt_r <= 2'd0;
    end else begin
      case ({pop_s, push_s})
        2'b10: begin
          fifoPc_r[0]    <= fifoPc_r[1];
          fifoInstr_r[0] <= fifoInstr_r[1];
          fifoCnt_r      <= fifoCnt_r - 2'd1;
        end
        2'b01: begin
          if (fifoCnt_r == 2'd0) begin
            fifoPc_r[0]    <= pcD1_r;
            fifoInstr_r[0] <= iInstr;
            fifoCnt_r      <= 2'd1;
          end else if (fifoCnt_r == 2'd1) begin
            fifoPc_r[1]    <= pcD1_r;
            fifoInstr_r[1] <= iInstr;
            fifoCnt_r      <= 2'd2;
          end else begin
            fifoCnt_r <= fifoCnt_r;
          end
        end
        2'b11: begin
          if (fifoCnt_r == 2'd1) begin
            fifoPc_r[0]    <= pcD1_r;
            fifoInstr_r[0] <= iInstr;
          end else begin
            fifoPc_r[0]    <= fifoPc_r[1];
            fifoInstr_r[0] <= fifoInstr_r[1];
            fifoPc_r[1]    <= pcD1_r;
            fifoInstr_r[1] <= iInstr;
          end
        end
        default: fifoCnt_r <= fifoCnt_r;
      endcase
    end
  end

  // Decoded output register; when not loading it holds, but operands track writes.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oValid   <= 1'b0;
      oPc      <= {cXLEN{1'b0}};
      oInstr   <= {cXLEN{1'b0}};
      oOpcode  <= 7'd0;
      oFunct3  <= 3'd0;
      oFunct7  <= 7'd0;
      oRdAddr  <= 5'd0;
      oRs1Addr <= 5'd0;
      oRs2Addr <= 5'd0;
      oRs1Data <= {cXLEN{1'b0}};
      oRs2Data <= {cXLEN{1'b0}};
      oImm     <= {cXLEN{1'b0}};
      oIllegal <= 1'b0;
    end else if (loadOut_s) begin
      oValid   <= 1'b1;
      oPc      <= srcPc_s;
      oInstr   <= srcInstr_s;
      oOpcode  <= srcInstr_s[6:0];
      oFunct3  <= srcInstr_s[14:12];
      oFunct7  <= srcInstr_s[31:25];
      oRdAddr  <= srcInstr_s[11:7];
      oRs1Addr <= rs1_s;
      oRs2Addr <= rs2_s;
      oRs1Data <= rs1Data_s;
      oRs2Data <= rs2Data_s;
      oImm     <= imm_s;
      oIllegal <= ill_s;
    end else begin
      oValid   <= oValid & iStall & ~iFlush;
      oRs1Data <= heldRs1_s;
      oRs2Data <= heldRs2_s;
    end
  end

  decode_stage_chk uChk (
    .iClk      (iClk),
    .iRst      (iRst),
    .iOverflow (overflow_s)
  );

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a small fetch/RAM model feeds a table of decode vectors,
// then hand-written stall, flush, held-operand and reset-mid-stall sequences.

module tb_decode_stage;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic [31:0] iCurPc = 32'd0;
  logic [31:0] iInstr = 32'd0;
  logic        iFlush = 1'b0;
  logic        iStall = 1'b0;
  logic        iRegWrDv = 1'b0;
  logic [4:0]  iRegWrAddr = 5'd0;
  logic [31:0] iRegWrData = 32'd0;
  logic        oFetchNoOp, oValid, oIllegal;
  logic [31:0] oPc, oInstr, oRs1Data, oRs2Data, oImm;
  logic [6:0]  oOpcode, oFunct7;
  logic [2:0]  oFunct3;
  logic [4:0]  oRdAddr, oRs1Addr, oRs2Addr;

  always #5 iClk = ~iClk;

  decode_stage #(.cXLEN(32), .cRegNum(32)) dut (
    .iClk(iClk), .iRst(iRst), .iCurPc(iCurPc), .iInstr(iInstr),
    .iFlush(iFlush), .iStall(iStall), .iRegWrDv(iRegWrDv),
    .iRegWrAddr(iRegWrAddr), .iRegWrData(iRegWrData), .oFetchNoOp(oFetchNoOp),
    .oValid(oValid), .oPc(oPc), .oInstr(oInstr), .oOpcode(oOpcode),
    .oFunct3(oFunct3), .oFunct7(oFunct7), .oRdAddr(oRdAddr), .oRs1Addr(oRs1Addr),
    .oRs2Addr(oRs2Addr), .oRs1Data(oRs1Data), .oRs2Data(oRs2Data), .oImm(oImm),
    .oIllegal(oIllegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic        wrDv;
    logic [4:0]  wrAddr;
    logic [31:0] wrData;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, d1, d2;
    logic        ill;
  } vec_t;

  localparam int NV = 9;
  vec_t        vecs [NV];
  vec_t        e;
  logic [31:0] mem [128];
  logic [31:0] fpc = 32'd0, prevPc = 32'd0, resetPc = 32'd0, flushTgt = 32'd0, expPc;
  logic [31:0] stPc [8];
  logic        stStall [8];
  int          nChecks = 0;
  int          nErrors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: fetch advances unless redirected or held by noOp, RAM returns last cycle's word.
  task automatic tick();
    @(posedge iClk);
    prevPc = iCurPc;
    if (iRst) fpc = resetPc;
    else if (iFlush) fpc = flushTgt;
    else if (!iStall) fpc = fpc + 32'd4;
    @(negedge iClk);
    iCurPc = fpc;
    iInstr = mem[prevPc[8:2]];
  endtask

  task automatic doReset(input logic [31:0] pc);
    resetPc  = pc;
    iRst     = 1'b1;
    iStall   = 1'b0;
    iFlush   = 1'b0;
    iRegWrDv = 1'b0;
    tick();
    tick();
    iRst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h00500093, 1'b0, 5'd0, 32'h0,        5'd1,  5'd0, 5'd5, 32'd5,        32'h0,        32'h0,        1'b0};
    vecs[1] = '{32'hFE112E23, 1'b1, 5'd1, 32'h11,       5'd28, 5'd2, 5'd1, 32'hFFFFFFFC, 32'h0,        32'h11,       1'b0};
    vecs[2] = '{32'h000000EF, 1'b1, 5'd0, 32'h1,        5'd1,  5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0};
    vecs[3] = '{32'h123450B7, 1'b0, 5'd0, 32'h0,        5'd1,  5'd8, 5'd3, 32'h12345000, 32'h0,        32'h0,        1'b0};
    vecs[4] = '{32'h00318233, 1'b1, 5'd3, 32'hDEADBEEF, 5'd4,  5'd3, 5'd3, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[5] = '{32'h00000000, 1'b0, 5'd0, 32'h0,        5'd0,  5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b1};
    vecs[6] = '{32'h00118333, 1'b0, 5'd0, 32'h0,        5'd6,  5'd3, 5'd1, 32'h0,        32'hDEADBEEF, 32'h11,       1'b0};
    vecs[7] = '{32'h0000000F, 1'b0, 5'd0, 32'h0,        5'd0,  5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0};
    vecs[8] = '{32'hFE000EE3, 1'b0, 5'd0, 32'h0,        5'd29, 5'd0, 5'd0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b0};
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    mem[0] = 32'h005283B3;  // A: add x7,x5,x5
    mem[1] = 32'h00100113;  // B
    mem[2] = 32'h00200193;  // C
    mem[3] = 32'h00300213;  // D
    for (int i = 0; i < NV; i++) mem[4+i] = vecs[i].instr;
    mem[64] = 32'h00128113; // flush target 0x100: addi x2,x5,1
    stPc    = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    stStall = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Table-driven decode stream starting at 0x10.
    doReset(32'h10);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_pc", oPc, 32'd0);
    chk("rst_instr", oInstr, 32'd0);
    chk("rst_imm", oImm, 32'd0);
    chk("rst_rd", 32'(oRdAddr), 32'd0);
    chk("rst_rs1data", oRs1Data, 32'd0);
    chk("rst_noop", 32'(oFetchNoOp), 32'd0);
    for (int i = 0; i <= NV; i++) begin
      tick();
      if (i < NV) begin
        iRegWrDv   = vecs[i].wrDv;
        iRegWrAddr = vecs[i].wrAddr;
        iRegWrData = vecs[i].wrData;
      end else begin
        iRegWrDv = 1'b0;
      end
      if (i == 0) begin
        chk("squash_valid", 32'(oValid), 32'd0);
      end else begin
        e     = vecs[i-1];
        expPc = 32'h10 + 32'(4 * (i - 1));
        chk("vec_valid", 32'(oValid), 32'd1);
        chk("vec_pc", oPc, expPc);
        chk("vec_instr", oInstr, e.instr);
        chk("vec_opcode", 32'(oOpcode), 32'(e.instr[6:0]));
        chk("vec_funct3", 32'(oFunct3), 32'(e.instr[14:12]));
        chk("vec_funct7", 32'(oFunct7), 32'(e.instr[31:25]));
        chk("vec_rd", 32'(oRdAddr), 32'(e.rd));
        chk("vec_rs1", 32'(oRs1Addr), 32'(e.rs1));
        chk("vec_rs2", 32'(oRs2Addr), 32'(e.rs2));
        chk("vec_imm", oImm, e.imm);
        chk("vec_rs1data", oRs1Data, e.d1);
        chk("vec_rs2data", oRs2Data, e.d2);
        chk("vec_illegal", 32'(oIllegal), 32'(e.ill));
      end
    end

    // Stall ordering: A held three cycles, then B, C, D back to back.
    doReset(32'h0);
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("stall_valid", 32'(oValid), 32'd1);
      chk("stall_pc", oPc, stPc[k]);
      chk("stall_instr", oInstr, mem[k - k + stPc[k][8:2]]);
      iStall = stStall[k];
      #1;
      chk("stall_noop", 32'(oFetchNoOp), 32'(stStall[k]));
    end

    // Flush with stall while B is on the output, then held-operand update and reset mid-stall.
    doReset(32'h0);
    tick();
    tick();
    tick();
    chk("fl_b_pc", oPc, 32'h4);
    chk("fl_b_valid", 32'(oValid), 32'd1);
    iFlush   = 1'b1;
    iStall   = 1'b1;
    flushTgt = 32'h100;
    #1;
    chk("fl_noop", 32'(oFetchNoOp), 32'd0);
    tick();
    iFlush = 1'b0;
    iStall = 1'b0;
    chk("fl_gap1", 32'(oValid), 32'd0);
    tick();
    chk("fl_gap2", 32'(oValid), 32'd0);
    tick();
    chk("fl_tgt_valid", 32'(oValid), 32'd1);
    chk("fl_tgt_pc", oPc, 32'h100);
    chk("fl_tgt_imm", oImm, 32'd1);
    chk("fl_tgt_rs1", 32'(oRs1Addr), 32'd5);
    chk("fl_tgt_rs1data", oRs1Data, 32'd0);
    iStall     = 1'b1;
    iRegWrDv   = 1'b1;
    iRegWrAddr = 5'd5;
    iRegWrData = 32'd7;
    tick();
    iRegWrDv = 1'b0;
    chk("held_pc", oPc, 32'h100);
    chk("held_rs1data", oRs1Data, 32'd7);
    tick();
    chk("held_valid", 32'(oValid), 32'd1);
    iRst = 1'b1;
    tick();
    iRst   = 1'b0;
    iStall = 1'b0;
    chk("rstmid_valid", 32'(oValid), 32'd0);
    chk("rstmid_pc", oPc, 32'd0);
    tick();
    chk("rstmid_squash", 32'(oValid), 32'd0);
    tick();
    chk("rstmid_a_valid", 32'(oValid), 32'd1);
    chk("rstmid_a_pc", oPc, 32'd0);
    chk("rstmid_a_instr", oInstr, 32'h005283B3);
    chk("rstmid_a_rs1data", oRs1Data, 32'd0);
    tick();
    chk("rstmid_b_pc", oPc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
